seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised-width ALU for the datapath. It is the successor to the combinational ALU. Single-cycle logic and shift ops sit alongside iterative signed Booth multiply and non-restoring signed divide, behind a start/busy/done handshake. Results are registered into a 2×WIDTH {HI,LO} pair that feeds the HI/LO and Z registers.

## Interface
- WIDTH, 32, operand width; even, ≥8
- clock  in  1  system clock
- clear  in  1  asynchronous, active-low reset
- start  in  1  launch op; sampled only when busy=0
- op  in  4  opcode (seq_alu_pkg::op_t): ADD=0 SUB=1 AND=2 OR=3 SHR=4 SHRA=5 SHL=6 ROR=7 ROL=8 NEG=9 NOT=10 MUL=11 DIV=12; 13–15 illegal
- a  in  WIDTH  operand A / dividend / multiplicand
- b  in  WIDTH  operand B / divisor / multiplier / shift amount
- busy  out  1  op in flight
- done  out  1  one-cycle pulse when result_hi/result_lo update
- result_lo  out  WIDTH  low word / quotient
- result_hi  out  WIDTH  high word / remainder
- div_zero  out  1  last DIV had b=0
- illegal  out  1  last op code was illegal

## Operation
- FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX.
- a, b and op are captured at the accepted start edge. Later input changes do not affect the op in flight.
- Single-cycle ops (ADD…NOT) and illegal codes:
  - Stay in IDLE.
  - Results register on the accept edge.
  - hi = 0.
  - Illegal code: lo = 0, illegal = 1.
- ADD/SUB: modulo 2^WIDTH; SUB = a + ~b + 1.
- NEG: lo = −a. NOT: lo = ~a.
- Shifts use b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
  - SHRA fills with a[WIDTH-1].
  - ROR/ROL wrap.
- MUL: signed × signed.
  - Radix-2 Booth, one partial product per cycle, WIDTH iterations.
  - Full 2×WIDTH product; {hi,lo} = a*b.
- DIV: signed non-restoring.
  - WIDTH iterations in DIV_RUN.
  - One correction cycle in DIV_FIX.
  - Quotient truncates toward zero; remainder takes the dividend's sign. lo = quotient, hi = remainder.
- Divide by zero:
  - Handled in IDLE with no iteration.
  - lo = all ones, hi = a, div_zero = 1.
- Overflow case (most negative value) / −1: lo = the most negative value, hi = 0.
- div_zero and illegal update only with done and hold until the next done.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: busy=0, done=0, result_lo=0, result_hi=0, div_zero=0, illegal=0. The FSM goes to IDLE.
- Latency is counted from the accept edge (cycle 0) to the done pulse:
  - Single-cycle, illegal and div-by-zero: done is high in cycle 1.
  - MUL: done in cycle WIDTH+1.
  - DIV: done in cycle WIDTH+2.
- busy rises in cycle 1 for MUL/DIV and falls in the same cycle done is high.
- A new start is accepted in the done cycle (busy=0), so ops can run back-to-back.
- Results are stable from done until the next done. Intermediate iteration state is never visible on result_*.
- clear asserted mid-op: the op is aborted immediately, all outputs return to reset values, and no done is produced.
- Iteration counter width is $clog2(WIDTH)+1. The counter runs down to 0; there is no wrap.

## Configuration
- SEQ_ALU_BOOTH_R4_EN
  - Defined: MUL uses radix-4 Booth, two bits per cycle. MUL done moves to cycle WIDTH/2+1.
  - Undefined: radix-2 behaviour as above.
- Results are identical in both builds. DIV timing is unaffected.

## Structure
- seq_alu_pkg holds:
  - op_t enum and opcode constants
  - state_t enum
  - latency constants: MUL_CYCLES (dependent on SEQ_ALU_BOOTH_R4_EN) and DIV_CYCLES, as functions of WIDTH
- Sub-module seq_alu_shifter: combinational barrel shifter for SHR/SHRA/SHL/ROR/ROL, parametrised by WIDTH.
- The FSM, Booth and divide datapaths stay in seq_alu.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → done in cycle 1; lo=0x80000000, hi=0. Then NEG a=0x80000000 → lo=0x80000000.
- MUL a=0xFFFFFFFD (−3), b=7 → {hi,lo}=0xFFFFFFFF_FFFFFFEB.
  - done in cycle 33, or cycle 17 with SEQ_ALU_BOOTH_R4_EN.
  - busy high cycles 1–32.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; done in cycle 34.
- DIV edge cases:
  - a=0x12345678, b=0 → cycle 1 done; lo=0xFFFFFFFF, hi=0x12345678, div_zero=1.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- ROL a=0x80000001, b=33 → lo=0x00000003. SHRA a=0x80000000, b=4 → lo=0xF8000000.
- Start MUL; pulse start=1 with an ADD at cycle 5 → the ADD is ignored. Assert clear at cycle 10 → busy=0, results=0, and no done follows.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and latency helpers shared by the seq_alu slice.
// SEQ_ALU_BOOTH_R4_EN switches multiply latency to the radix-4 Booth schedule.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_NEG  = 4'd9,
        OP_NOT  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_t;

    // Cycles from the accept edge to the done pulse.
    function automatic int mul_cycles(input int width);
`ifdef SEQ_ALU_BOOTH_R4_EN
        return width / 2 + 1;
`else
        return width + 1;
`endif
    endfunction

    function automatic int div_cycles(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: combinational barrel shifter / rotator for SHR, SHRA, SHL, ROR and ROL.
module seq_alu_shifter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] sh,
    output logic [WIDTH-1:0]         y
);
    localparam int SH_W = $clog2(WIDTH);

    // Complementary amount for the wrap-around half of a rotate; equals WIDTH when sh=0.
    logic [SH_W:0] sh_inv;
    assign sh_inv = (SH_W+1)'(WIDTH) - {1'b0, sh};

    always_comb begin
        y = '0;
        case (op)
            OP_SHR:  y = a >> sh;
            OP_SHRA: y = $unsigned($signed(a) >>> sh);
            OP_SHL:  y = a << sh;
            OP_ROR:  y = (a >> sh) | (a << sh_inv);
            OP_ROL:  y = (a << sh) | (a >> sh_inv);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU -- single-cycle logic/shift ops, signed Booth multiply and signed
// non-restoring divide behind start/busy/done. SEQ_ALU_BOOTH_R4_EN selects radix-4 Booth.
//
//   state      | meaning
//   ST_IDLE    | waiting for start; single-cycle ops, illegal codes and divide-by-zero finish here
//   ST_MUL_RUN | one Booth partial product per cycle
//   ST_DIV_RUN | one non-restoring quotient bit per cycle on operand magnitudes
//   ST_DIV_FIX | remainder correction and sign fix-up, result registered
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic             illegal
);
    localparam int SH_W       = $clog2(WIDTH);
    localparam int CNT_W      = SH_W + 1;
    localparam int ACC_W      = WIDTH + 2;
    localparam int MUL_CYCLES = mul_cycles(WIDTH);
    localparam int DIV_CYCLES = div_cycles(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 3);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic             q_m1;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             is_last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ill;
    logic [ACC_W-1:0] mcand_x, booth_sum, acc_mul;
    logic [WIDTH-1:0] mq_mul;
    logic             q_m1_mul;
    logic [ACC_W-1:0] dvsr_x, rem_sh, rem_step;
    logic [WIDTH-1:0] quo_step, rem_fix, quo_out, rem_out;

    assign accept  = start && (state == ST_IDLE);
    assign is_last = (cnt == '0);
    assign busy    = (state != ST_IDLE);
    assign a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;

    seq_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .op (op),
        .a  (a),
        .sh (b[SH_W-1:0]),
        .y  (shift_y)
    );

    always_comb begin
        sc_lo  = '0;
        sc_ill = 1'b0;
        case (op)
            OP_ADD:  sc_lo = a + b;
            OP_SUB:  sc_lo = a + ~b + 1'b1;
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     sc_lo = shift_y;
            OP_NEG:  sc_lo = ~a + 1'b1;
            OP_NOT:  sc_lo = ~a;
            OP_MUL, OP_DIV:
                     sc_lo = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // Booth step: accumulate into the sign-extended upper half, then arithmetic shift right.
    assign mcand_x = {{2{opnd[WIDTH-1]}}, opnd};

`ifdef SEQ_ALU_BOOTH_R4_EN
    always_comb begin
        booth_sum = acc;
        case ({mq[1:0], q_m1})
            3'b001, 3'b010: booth_sum = acc + mcand_x;
            3'b011:         booth_sum = acc + (mcand_x << 1);
            3'b100:         booth_sum = acc - (mcand_x << 1);
            3'b101, 3'b110: booth_sum = acc - mcand_x;
            default:        booth_sum = acc;
        endcase
        {acc_mul, mq_mul, q_m1_mul} = {{2{booth_sum[ACC_W-1]}}, booth_sum, mq[WIDTH-1:1]};
    end
`else
    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + mcand_x;
            2'b10:   booth_sum = acc - mcand_x;
            default: booth_sum = acc;
        endcase
        {acc_mul, mq_mul, q_m1_mul} = {booth_sum[ACC_W-1], booth_sum, mq};
    end
`endif

    // Non-restoring step on magnitudes; acc holds the signed partial remainder.
    assign dvsr_x   = {2'b00, opnd};
    assign rem_sh   = {acc[ACC_W-2:0], mq[WIDTH-1]};
    assign rem_step = acc[ACC_W-1] ? (rem_sh + dvsr_x) : (rem_sh - dvsr_x);
    assign quo_step = {mq[WIDTH-2:0], ~rem_step[ACC_W-1]};
    assign rem_fix  = acc[ACC_W-1] ? (acc[WIDTH-1:0] + opnd) : acc[WIDTH-1:0];
    assign quo_out  = sign_q ? (~mq + 1'b1) : mq;
    assign rem_out  = sign_r ? (~rem_fix + 1'b1) : rem_fix;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL)
                        state_nxt = ST_MUL_RUN;
                    else if ((op == OP_DIV) && (b != '0))
                        state_nxt = ST_DIV_RUN;
                end
            end
            ST_MUL_RUN: if (is_last) state_nxt = ST_IDLE;
            ST_DIV_RUN: if (is_last) state_nxt = ST_DIV_FIX;
            ST_DIV_FIX: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mq        <= '0;
            opnd      <= '0;
            q_m1      <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            acc  <= '0;
                            mq   <= b;
                            q_m1 <= 1'b0;
                            opnd <= a;
                            cnt  <= MUL_LAST;
                        end else if ((op == OP_DIV) && (b == '0)) begin
                            result_lo <= '1;
                            result_hi <= a;
                            div_zero  <= 1'b1;
                            illegal   <= 1'b0;
                            done      <= 1'b1;
                        end else if (op == OP_DIV) begin
                            acc    <= '0;
                            mq     <= a_mag;
                            opnd   <= b_mag;
                            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r <= a[WIDTH-1];
                            cnt    <= DIV_LAST;
                        end else begin
                            result_lo <= sc_lo;
                            result_hi <= '0;
                            div_zero  <= 1'b0;
                            illegal   <= sc_ill;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    acc  <= acc_mul;
                    mq   <= mq_mul;
                    q_m1 <= q_m1_mul;
                    if (is_last) begin
                        result_hi <= acc_mul[WIDTH-1:0];
                        result_lo <= mq_mul;
                        div_zero  <= 1'b0;
                        illegal   <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DIV_RUN: begin
                    acc <= rem_step;
                    mq  <= quo_step;
                    if (!is_last)
                        cnt <= cnt - CNT_W'(1);
                end
                ST_DIV_FIX: begin
                    result_lo <= quo_out;
                    result_hi <= rem_out;
                    div_zero  <= 1'b0;
                    illegal   <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table, multi-cycle corner sequences and random ops against a
// plain-arithmetic reference model of seq_alu (WIDTH=32).
module tb_seq_alu;
    localparam int W = 32;
`ifdef SEQ_ALU_BOOTH_R4_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 2;

    localparam logic [3:0] T_ADD = 4'd0,  T_SUB = 4'd1,  T_AND = 4'd2,  T_OR  = 4'd3;
    localparam logic [3:0] T_SHR = 4'd4,  T_SHRA = 4'd5, T_SHL = 4'd6,  T_ROR = 4'd7;
    localparam logic [3:0] T_ROL = 4'd8,  T_NEG = 4'd9,  T_NOT = 4'd10, T_MUL = 4'd11;
    localparam logic [3:0] T_DIV = 4'd12;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_zero, illegal;
    logic [W-1:0] result_lo, result_hi;

    seq_alu #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic and per-bit rotation.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz, output logic ill, output int lat);
        longint sx, sy, p, q, r;
        int     sh;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sh  = int'(y % W);
        lo  = '0;
        hi  = '0;
        dz  = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (o)
            T_ADD:  lo = x + y;
            T_SUB:  lo = x - y;
            T_AND:  lo = x & y;
            T_OR:   lo = x | y;
            T_SHR:  lo = x >> sh;
            T_SHRA: lo = $signed(x) >>> sh;
            T_SHL:  lo = x << sh;
            T_ROR:  for (int i = 0; i < W; i++) lo[i] = x[(i + sh) % W];
            T_ROL:  for (int i = 0; i < W; i++) lo[(i + sh) % W] = x[i];
            T_NEG:  lo = 0 - x;
            T_NOT:  lo = ~x;
            T_MUL: begin
                p = sx * sy;
                {hi, lo} = p;
                lat = MUL_LAT;
            end
            T_DIV: begin
                if (y == 0) begin
                    lo = '1;
                    hi = x;
                    dz = 1'b1;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    lo  = q[W-1:0];
                    hi  = r[W-1:0];
                    lat = DIV_LAT;
                end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cycles, output logic busy_at_done);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 4'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat   = 0;
        busy_cycles  = 0;
        busy_at_done = 1'b1;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (done) begin
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                            input logic e_dz, input logic e_ill, input int e_lat);
        int   lat, bc;
        logic bd;
        run_op(o, x, y, lat, bc, bd);
        check({tag, ".lo"}, result_lo, e_lo);
        check({tag, ".hi"}, result_hi, e_hi);
        check({tag, ".div_zero"}, div_zero, e_dz);
        check({tag, ".illegal"}, illegal, e_ill);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".busy_cycles"}, bc, e_lat - 1);
        check({tag, ".busy_at_done"}, bd, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           ndone, done_cyc;
        logic [W-1:0] lo_s, hi_s;
        logic [W-1:0] m_lo, m_hi, rx, ry;
        logic         m_dz, m_ill;
        int           m_lat, sel;
        logic [3:0]   ro;

        vecs.push_back('{T_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_NEG,  32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, MUL_LAT});
        vecs.push_back('{T_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, DIV_LAT});
        vecs.push_back('{T_DIV,  32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1});
        vecs.push_back('{T_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, DIV_LAT});
        vecs.push_back('{T_ROL,  32'h80000001, 32'd33,       32'h00000003, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_SHRA, 32'h80000000, 32'd4,        32'hF8000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd13,  32'hDEADBEEF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1});
        vecs.push_back('{T_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_MUL,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, MUL_LAT});
        vecs.push_back('{T_MUL,  32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 1'b0, MUL_LAT});
        vecs.push_back('{T_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, DIV_LAT});
        vecs.push_back('{T_DIV,  32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0, DIV_LAT});
        vecs.push_back('{T_ROR,  32'h00000001, 32'd1,        32'h80000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_SHL,  32'h00000001, 32'd31,       32'h80000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_SHR,  32'h80000000, 32'h0000003F, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_NOT,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{T_SHRA, 32'h7FFFFFFF, 32'd4,        32'h07FFFFFF, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd15,  32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1});
        vecs.push_back('{T_MUL,  32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0, MUL_LAT});

        // Reset values
        repeat (3) @(negedge clock);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.lo", result_lo, '0);
        check("reset.hi", result_hi, '0);
        check("reset.div_zero", div_zero, 1'b0);
        check("reset.illegal", illegal, 1'b0);
        clear = 1'b1;
        @(negedge clock);

        // Table vectors, issued back-to-back in the done cycle of the previous op
        for (int i = 0; i < vecs.size(); i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].ill, vecs[i].lat);

        // MUL in flight: inputs change and an ADD start is pulsed at cycle 5
        start = 1'b1; op = T_MUL; a = 32'hFFFFFFFD; b = 32'h00000007;
        @(posedge clock);
        #1;
        start = 1'b0; a = 32'h00000001; b = 32'h00000001; op = T_ADD;
        ndone = 0; done_cyc = -1; lo_s = '0; hi_s = '0;
        for (int c = 1; c <= MUL_LAT + 6; c++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
                lo_s = result_lo;
                hi_s = result_hi;
            end
            start = (c == 5);
        end
        start = 1'b0;
        check("ignored_start.done_count", ndone, 1);
        check("ignored_start.done_cycle", done_cyc, MUL_LAT);
        check("ignored_start.product", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFEB);

        // Abort by clear at cycle 10 of a MUL, with non-zero results and div_zero set beforehand
        check_op("pre_clear", T_DIV, 32'h0BADF00D, 32'h0, 32'hFFFFFFFF, 32'h0BADF00D, 1'b1, 1'b0, 1);
        start = 1'b1; op = T_MUL; a = 32'h00000003; b = 32'h00000005;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clock);
        clear = 1'b0;
        #1;
        check("clear.busy", busy, 1'b0);
        check("clear.done", done, 1'b0);
        check("clear.lo", result_lo, '0);
        check("clear.hi", result_hi, '0);
        check("clear.div_zero", div_zero, 1'b0);
        check("clear.illegal", illegal, 1'b0);
        @(negedge clock);
        clear = 1'b1;
        ndone = 0;
        for (int c = 0; c < MUL_LAT + 10; c++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("clear.no_done", ndone, 0);
        check_op("after_clear", T_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1);

        // Random ops against the reference model
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 21);
            if (sel > 15) ro = sel[0] ? T_MUL : T_DIV;
            else          ro = 4'(sel);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: rx = 32'h80000000;
                1: rx = 32'h00000000;
                default: ;
            endcase
            case ($urandom_range(0, 7))
                0: ry = 32'h00000000;
                1: ry = 32'hFFFFFFFF;
                2: ry = 32'($urandom_range(1, 40));
                default: ;
            endcase
            model(ro, rx, ry, m_lo, m_hi, m_dz, m_ill, m_lat);
            check_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, m_lo, m_hi, m_dz, m_ill, m_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
